// File: rtl/uart_rx_store.sv
// 8N1 UART receiver with 16x oversampling. Each good byte becomes a one-clock
// RAM write strobe at an address that advances by one after every write.
module uart_rx_store #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] wr_data,
  output logic [7:0] addr,
  output logic       wr_en,
  output logic       frame_err,
  output logic       busy,
  output logic [2:0] state_dbg
);

  localparam int DIV = CLK_FREQ / (16 * BAUD);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] DIV_M1 = TW'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t        state;
  logic          rx_m;
  logic          rx_s;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [3:0]    sample_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  // Synchronizer resets to the idle level so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Oversampling tick; held at zero in IDLE so it restarts on each start bit.
  assign tick = (state != S_IDLE) && (tick_cnt == DIV_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (state == S_IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      sample_cnt <= 4'd0;
      bit_cnt    <= 3'd0;
      shift      <= 8'h00;
      wr_data    <= 8'h00;
      addr       <= 8'h00;
      wr_en      <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      if (wr_en) begin
        addr <= addr + 8'd1;
      end
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state      <= S_START;
            sample_cnt <= 4'd0;
          end
        end
        S_START: begin
          if (tick) begin
            if (sample_cnt == 4'd7) begin
              sample_cnt <= 4'd0;
              bit_cnt    <= 3'd0;
              state      <= rx_s ? S_IDLE : S_DATA;
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
        end
        S_DATA: begin
          if (tick) begin
            if (sample_cnt == 4'd15) begin
              sample_cnt <= 4'd0;
              shift      <= {rx_s, shift[7:1]};
              if (bit_cnt == 3'd7) begin
                bit_cnt <= 3'd0;
                state   <= S_STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
        end
        S_STOP: begin
          if (tick) begin
            if (sample_cnt == 4'd15) begin
              sample_cnt <= 4'd0;
              if (rx_s) begin
                wr_data <= shift;
                wr_en   <= 1'b1;
                state   <= S_IDLE;
              end else begin
                frame_err <= 1'b1;
                state     <= S_BREAK;
              end
            end else begin
              sample_cnt <= sample_cnt + 4'd1;
            end
          end
        end
        S_BREAK: begin
          // One error per break: stay here until the line returns to idle.
          if (rx_s) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_uart_rx_store.sv
// Directed bench for uart_rx_store: a DIV=10 instance for timing-accurate cases
// and a DIV=1 instance for the 257-frame address wrap sweep.
module tb_uart_rx_store;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] wr_data;
  logic [7:0] addr;
  logic       wr_en;
  logic       frame_err;
  logic       busy;
  logic [2:0] state_dbg;

  logic       rx_f;
  logic [7:0] f_wr_data;
  logic [7:0] f_addr;
  logic       f_wr_en;
  logic       f_frame_err;
  logic       f_busy;
  logic [2:0] f_state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [7:0]  m_addr_q[$];
  logic [7:0]  m_data_q[$];
  int          fe_cnt = 0;
  int          wr_cyc = 0;
  logic [7:0]  f_addr_q[$];
  logic [7:0]  f_data_q[$];
  int          f_fe_cnt = 0;
  logic [15:0] exp_q[$];

  uart_rx_store #(.CLK_FREQ(1_600_000), .BAUD(10_000)) dut (
    .clk(clk), .rst(rst), .rx(rx), .wr_data(wr_data), .addr(addr),
    .wr_en(wr_en), .frame_err(frame_err), .busy(busy), .state_dbg(state_dbg)
  );

  uart_rx_store #(.CLK_FREQ(160_000), .BAUD(10_000)) dut_fast (
    .clk(clk), .rst(rst), .rx(rx_f), .wr_data(f_wr_data), .addr(f_addr),
    .wr_en(f_wr_en), .frame_err(f_frame_err), .busy(f_busy), .state_dbg(f_state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write / error monitors, sampled on the falling edge
  always @(negedge clk) begin
    if (wr_en) begin
      m_addr_q.push_back(addr);
      m_data_q.push_back(wr_data);
      wr_cyc = cyc;
    end
    if (frame_err) fe_cnt++;
    if (f_wr_en) begin
      f_addr_q.push_back(f_addr);
      f_data_q.push_back(f_wr_data);
    end
    if (f_frame_err) f_fe_cnt++;
  end

  // Driver tasks
  task automatic drive_line(input bit fast, input logic v, input int n);
    if (fast) rx_f = v;
    else rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input bit fast, input logic [7:0] b, input int bit_clks,
                            input logic stop_val);
    drive_line(fast, 1'b0, bit_clks);
    for (int i = 0; i < 8; i++) drive_line(fast, b[i], bit_clks);
    drive_line(fast, stop_val, bit_clks);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx = 1'b1;
    rx_f = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (addr !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", addr); end
    n_tests++;
    if (wr_data !== 8'h00) begin n_fail++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    n_tests++;
    if ({wr_en, frame_err, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_strobes: got %b want 000", {wr_en, frame_err, busy});
    end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_tests++;
    if ({busy, f_busy} !== 2'b00) begin
      n_fail++; $display("FAIL reset_no_false_start: busy got %b want 00", {busy, f_busy});
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 257; i++) begin
      exp_q.push_back({i[7:0], i[7:0]});
      send_frame(1'b1, i[7:0], 16, 1'b1);
    end
    drive_line(1'b1, 1'b1, 100);
    n_tests++;
    if (f_addr_q.size() !== 257) begin
      n_fail++; $display("FAIL b2b_count: got %0d writes want 257", f_addr_q.size());
    end
    n_tests++;
    if (f_addr_q.size() >= 256 && f_addr_q[255] !== 8'hFF) begin
      n_fail++; $display("FAIL b2b_256th_addr: got %h want ff", f_addr_q[255]);
    end
    n_tests++;
    if (f_addr_q.size() >= 257 && {f_addr_q[256], f_data_q[256]} !== 16'h0000) begin
      n_fail++; $display("FAIL b2b_257th: got %h/%h want 00/00", f_addr_q[256], f_data_q[256]);
    end
    for (int i = 0; i < 257 && i < f_addr_q.size(); i++) begin
      logic [15:0] exp;
      exp = exp_q.pop_front();
      n_tests++;
      if ({f_addr_q[i], f_data_q[i]} !== exp) begin
        n_fail++;
        $display("FAIL b2b_write_%0d: got addr/data %h want %h", i, {f_addr_q[i], f_data_q[i]}, exp);
      end
    end
    n_tests++;
    if (f_fe_cnt !== 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d want 0", f_fe_cnt); end
  endtask

  task automatic test_single();
    int fall_cyc;
    fall_cyc = cyc;
    send_frame(1'b0, 8'hA5, 160, 1'b1);
    drive_line(1'b0, 1'b1, 100);
    n_tests++;
    if (m_addr_q.size() !== 1) begin
      n_fail++; $display("FAIL single_count: got %0d writes want 1", m_addr_q.size());
    end
    n_tests++;
    if (m_addr_q.size() >= 1 && {m_addr_q[0], m_data_q[0]} !== 16'h00A5) begin
      n_fail++; $display("FAIL single_write: got %h/%h want 00/a5", m_addr_q[0], m_data_q[0]);
    end
    n_tests++;
    if (wr_cyc - fall_cyc !== 1523) begin
      n_fail++; $display("FAIL single_latency: got %0d clk from rx fall want 1523", wr_cyc - fall_cyc);
    end
    n_tests++;
    if (addr !== 8'h01) begin n_fail++; $display("FAIL single_addr_after: got %h want 01", addr); end
    n_tests++;
    if (fe_cnt !== 0) begin n_fail++; $display("FAIL single_frame_err: got %0d want 0", fe_cnt); end
  endtask

  task automatic test_glitch();
    bit saw_busy;
    int w0;
    saw_busy = 1'b0;
    w0 = m_addr_q.size();
    rx = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (i == 40) rx = 1'b1;
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    n_tests++;
    if (saw_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_pulse: got 0 want 1"); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_end: got %b want 0", busy); end
    n_tests++;
    if (m_addr_q.size() !== w0 || fe_cnt !== 0) begin
      n_fail++; $display("FAIL glitch_outputs: writes %0d fe %0d want %0d/0", m_addr_q.size(), fe_cnt, w0);
    end
    n_tests++;
    if (addr !== 8'h01) begin n_fail++; $display("FAIL glitch_addr: got %h want 01", addr); end
  endtask

  task automatic test_break();
    int w0;
    w0 = m_addr_q.size();
    send_frame(1'b0, 8'h3C, 160, 1'b0);
    n_tests++;
    if (fe_cnt !== 1) begin n_fail++; $display("FAIL break_frame_err: got %0d clk want 1", fe_cnt); end
    n_tests++;
    if (m_addr_q.size() !== w0) begin
      n_fail++; $display("FAIL break_no_write: got %0d writes want %0d", m_addr_q.size(), w0);
    end
    drive_line(1'b0, 1'b0, 2000);
    n_tests++;
    if (fe_cnt !== 1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL break_hold: fe %0d busy %b want 1/1", fe_cnt, busy);
    end
    drive_line(1'b0, 1'b1, 50);
    n_tests++;
    if ({addr, wr_data, busy} !== {8'h01, 8'hA5, 1'b0}) begin
      n_fail++; $display("FAIL break_release: addr %h data %h busy %b want 01 a5 0", addr, wr_data, busy);
    end
    send_frame(1'b0, 8'h11, 160, 1'b1);
    drive_line(1'b0, 1'b1, 200);
    n_tests++;
    if (m_addr_q.size() !== w0 + 1 || {m_addr_q[$], m_data_q[$]} !== 16'h0111) begin
      n_fail++; $display("FAIL break_next_frame: got %h/%h want 01/11", m_addr_q[$], m_data_q[$]);
    end
  endtask

  task automatic test_baud_skew();
    int w0;
    w0 = m_addr_q.size();
    send_frame(1'b0, 8'h55, 157, 1'b1);
    drive_line(1'b0, 1'b1, 100);
    send_frame(1'b0, 8'hAA, 163, 1'b1);
    drive_line(1'b0, 1'b1, 200);
    n_tests++;
    if (m_addr_q.size() !== w0 + 2) begin
      n_fail++; $display("FAIL skew_count: got %0d writes want %0d", m_addr_q.size(), w0 + 2);
    end else begin
      n_tests++;
      if ({m_addr_q[w0], m_data_q[w0]} !== 16'h0255) begin
        n_fail++; $display("FAIL skew_fast: got %h/%h want 02/55", m_addr_q[w0], m_data_q[w0]);
      end
      n_tests++;
      if ({m_addr_q[w0+1], m_data_q[w0+1]} !== 16'h03AA) begin
        n_fail++; $display("FAIL skew_slow: got %h/%h want 03/aa", m_addr_q[w0+1], m_data_q[w0+1]);
      end
    end
    n_tests++;
    if (fe_cnt !== 1) begin n_fail++; $display("FAIL skew_frame_err: got %0d want 1", fe_cnt); end
  endtask

  task automatic test_mid_reset();
    logic [7:0] b;
    int w0;
    b = 8'h5A;
    drive_line(1'b0, 1'b0, 160);
    for (int i = 0; i < 4; i++) drive_line(1'b0, b[i], 160);
    drive_line(1'b0, b[4], 80);
    rst = 1'b1;
    #1;
    n_tests++;
    if ({addr, wr_data, wr_en, frame_err, busy} !== 19'h0) begin
      n_fail++;
      $display("FAIL midreset_outputs: addr %h data %h wr_en %b fe %b busy %b want all 0",
               addr, wr_data, wr_en, frame_err, busy);
    end
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    w0 = m_addr_q.size();
    drive_line(1'b0, 1'b1, 100);
    send_frame(1'b0, 8'h5A, 160, 1'b1);
    drive_line(1'b0, 1'b1, 200);
    n_tests++;
    if (m_addr_q.size() !== w0 + 1 || {m_addr_q[$], m_data_q[$]} !== 16'h005A) begin
      n_fail++; $display("FAIL midreset_frame: got %h/%h want 00/5a", m_addr_q[$], m_data_q[$]);
    end
    n_tests++;
    if (addr !== 8'h01) begin n_fail++; $display("FAIL midreset_addr_after: got %h want 01", addr); end
  endtask

  initial begin
    rst = 1'b1;
    rx = 1'b1;
    rx_f = 1'b1;
    @(negedge clk);
    test_reset();
    test_back_to_back();
    test_single();
    test_glitch();
    test_break();
    test_baud_skew();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
